// File: rtl/lsu_mem_stage_if.sv
// rtl/lsu_mem_stage_if.sv - request/grant data bus between the LSU and memory
interface lsu_mem_stage_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = XLEN / 8;

    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [NB-1:0]     bus_be_o;
    logic [XLEN-1:0]   bus_wdata_o;
    logic              bus_gnt_i;
    logic              bus_rvalid_i;
    logic [XLEN-1:0]   bus_rdata_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - sequential load/store memory stage with optional misaligned split
module lsu_mem_stage #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   st_data_i,
    input  logic [4:0]        rd_waddr_i,
    lsu_mem_stage_if.master   bus,
    output logic              rd_we_o,
    output logic [4:0]        rd_waddr_o,
    output logic [XLEN-1:0]   rd_data_o,
    output logic              hold_flag_o,
    output logic              misalign_o
);
    localparam int NB = XLEN / 8;
    localparam int LG = $clog2(NB);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} state_t;
    state_t state_q, state_d;

    logic              store_q, cross_q, misalign_q;
    logic [2:0]        f3_q;
    logic [3:0]        off_q, sz_q;
    logic [4:0]        end_q;
    logic [ADDR_W-1:0] base_q;
    logic [XLEN-1:0]   data_q, b0_q, b1_q;
    logic [4:0]        rd_q;

    logic [3:0] a_off, a_sz;
    logic [4:0] a_end;
    logic       a_cross, a_illegal, a_fault, in_idle, accept;

    assign in_idle   = (state_q == IDLE);
    assign a_off     = 4'(addr_i[LG-1:0]);
    assign a_sz      = 4'd1 << funct3_i[1:0];
    assign a_end     = {1'b0, a_off} + {1'b0, a_sz};
    assign a_cross   = a_end > 5'(NB);
    // Doubleword forms (ld/sd/lwu) only exist on a 64-bit datapath
    assign a_illegal = (is_store_i ? funct3_i[2] : (funct3_i == 3'b111))
                     || ((XLEN == 32) && ((funct3_i[1:0] == 2'b11) || (funct3_i == 3'b110)));
    assign a_fault   = a_illegal || (a_cross && !SPLIT_EN);
    assign accept    = in_idle && in_valid_i && !a_fault;

    logic [2*NB-1:0]   lane_mask;
    logic [2*XLEN-1:0] wide_wdata, wide_rdata;
    logic [XLEN-1:0]   merged, load_res;
    logic              sign_bit;

    // Lanes of both beats viewed as one 2*NB-byte window starting at beat 0
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            lane_mask[i] = (5'(i) >= {1'b0, off_q}) && (5'(i) < end_q);
        end
    end

    assign wide_wdata = {{XLEN{1'b0}}, data_q} << {off_q, 3'b000};
    assign wide_rdata = {b1_q, b0_q} >> {off_q, 3'b000};
    assign merged     = wide_rdata[XLEN-1:0];

    always_comb begin
        sign_bit = 1'b0;
        case (f3_q[1:0])
            2'b00:   sign_bit = merged[7];
            2'b01:   sign_bit = merged[15];
            default: sign_bit = merged[31];
        endcase
        load_res = '0;
        for (int i = 0; i < NB; i++) begin
            load_res[8*i +: 8] = (4'(i) < sz_q) ? merged[8*i +: 8] : {8{sign_bit & ~f3_q[2]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.bus_req_o   = 1'b0;
        bus.bus_we_o    = 1'b0;
        bus.bus_addr_o  = '0;
        bus.bus_be_o    = '0;
        bus.bus_wdata_o = '0;
        case (state_q)
            IDLE: if (accept) state_d = REQ0;
            REQ0: begin
                bus.bus_req_o   = 1'b1;
                bus.bus_we_o    = store_q;
                bus.bus_addr_o  = base_q;
                bus.bus_be_o    = lane_mask[NB-1:0];
                bus.bus_wdata_o = wide_wdata[XLEN-1:0];
                if (bus.bus_gnt_i) state_d = store_q ? (cross_q ? REQ1 : DONE) : WAIT0;
            end
            WAIT0: if (bus.bus_rvalid_i) state_d = cross_q ? REQ1 : DONE;
            REQ1: begin
                bus.bus_req_o   = 1'b1;
                bus.bus_we_o    = store_q;
                bus.bus_addr_o  = base_q + ADDR_W'(NB);
                bus.bus_be_o    = lane_mask[2*NB-1:NB];
                bus.bus_wdata_o = wide_wdata[2*XLEN-1:XLEN];
                if (bus.bus_gnt_i) state_d = store_q ? DONE : WAIT1;
            end
            WAIT1: if (bus.bus_rvalid_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q    <= 1'b0;
            cross_q    <= 1'b0;
            misalign_q <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            sz_q       <= '0;
            end_q      <= '0;
            base_q     <= '0;
            data_q     <= '0;
            rd_q       <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
        end else begin
            misalign_q <= in_idle && in_valid_i && a_fault;
            if (accept) begin
                store_q <= is_store_i;
                cross_q <= a_cross;
                f3_q    <= funct3_i;
                off_q   <= a_off;
                sz_q    <= a_sz;
                end_q   <= a_end;
                base_q  <= addr_i & ~ADDR_W'(NB - 1);
                data_q  <= st_data_i;
                rd_q    <= rd_waddr_i;
            end
            if (state_q == WAIT0 && bus.bus_rvalid_i) b0_q <= bus.bus_rdata_i;
            if (state_q == WAIT1 && bus.bus_rvalid_i) b1_q <= bus.bus_rdata_i;
        end
    end

    logic done_load;
    assign done_load   = (state_q == DONE) && !store_q;
    assign rd_we_o     = done_load && (rd_q != 5'd0);
    assign rd_waddr_o  = done_load ? rd_q : 5'd0;
    assign rd_data_o   = done_load ? load_res : '0;
    assign hold_flag_o = !in_idle;
    assign in_ready_o  = in_idle;
    assign misalign_o  = misalign_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - scoreboard bench for lsu_mem_stage (32-bit split, 32-bit no-split, 64-bit)
module tb_lsu_mem_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        t_store;
    logic [2:0]  t_f3;
    logic [31:0] t_addr;
    logic [63:0] t_sd;
    logic [4:0]  t_rd;
    logic        v32, v32n, v64;

    logic        rdy32, rdy32n, rdy64, rwe32, rwe32n, rwe64;
    logic [4:0]  rwa32, rwa32n, rwa64;
    logic [31:0] rd32, rd32n;
    logic [63:0] rd64;
    logic        hold32, hold32n, hold64, mis32, mis32n, mis64;

    lsu_mem_stage_if #(.XLEN(32), .ADDR_W(32)) b32 ();
    lsu_mem_stage_if #(.XLEN(32), .ADDR_W(32)) b32n ();
    lsu_mem_stage_if #(.XLEN(64), .ADDR_W(32)) b64 ();

    lsu_mem_stage #(.XLEN(32), .ADDR_W(32), .SPLIT_EN(1'b1)) u32 (
        .clk(clk), .rst(rst), .in_valid_i(v32), .in_ready_o(rdy32), .is_store_i(t_store),
        .funct3_i(t_f3), .addr_i(t_addr), .st_data_i(t_sd[31:0]), .rd_waddr_i(t_rd), .bus(b32),
        .rd_we_o(rwe32), .rd_waddr_o(rwa32), .rd_data_o(rd32), .hold_flag_o(hold32), .misalign_o(mis32));
    lsu_mem_stage #(.XLEN(32), .ADDR_W(32), .SPLIT_EN(1'b0)) u32n (
        .clk(clk), .rst(rst), .in_valid_i(v32n), .in_ready_o(rdy32n), .is_store_i(t_store),
        .funct3_i(t_f3), .addr_i(t_addr), .st_data_i(t_sd[31:0]), .rd_waddr_i(t_rd), .bus(b32n),
        .rd_we_o(rwe32n), .rd_waddr_o(rwa32n), .rd_data_o(rd32n), .hold_flag_o(hold32n), .misalign_o(mis32n));
    lsu_mem_stage #(.XLEN(64), .ADDR_W(32), .SPLIT_EN(1'b1)) u64 (
        .clk(clk), .rst(rst), .in_valid_i(v64), .in_ready_o(rdy64), .is_store_i(t_store),
        .funct3_i(t_f3), .addr_i(t_addr), .st_data_i(t_sd), .rd_waddr_i(t_rd), .bus(b64),
        .rd_we_o(rwe64), .rd_waddr_o(rwa64), .rd_data_o(rd64), .hold_flag_o(hold64), .misalign_o(mis64));

    logic        m_req [3], m_gnt [3], m_we [3], m_rwe [3], m_hold [3], m_mis [3], m_rdy [3];
    logic [31:0] m_addr [3];
    logic [7:0]  m_be [3];
    logic [63:0] m_wd [3], m_rd [3];
    logic [4:0]  m_rwa [3];

    assign m_req[0] = b32.bus_req_o;  assign m_req[1] = b32n.bus_req_o;  assign m_req[2] = b64.bus_req_o;
    assign m_gnt[0] = b32.bus_gnt_i;  assign m_gnt[1] = b32n.bus_gnt_i;  assign m_gnt[2] = b64.bus_gnt_i;
    assign m_we[0]  = b32.bus_we_o;   assign m_we[1]  = b32n.bus_we_o;   assign m_we[2]  = b64.bus_we_o;
    assign m_addr[0] = b32.bus_addr_o; assign m_addr[1] = b32n.bus_addr_o; assign m_addr[2] = b64.bus_addr_o;
    assign m_be[0]  = {4'b0, b32.bus_be_o}; assign m_be[1] = {4'b0, b32n.bus_be_o}; assign m_be[2] = b64.bus_be_o;
    assign m_wd[0]  = {32'b0, b32.bus_wdata_o}; assign m_wd[1] = {32'b0, b32n.bus_wdata_o};
    assign m_wd[2]  = b64.bus_wdata_o;
    assign m_rwe[0] = rwe32;  assign m_rwe[1] = rwe32n;  assign m_rwe[2] = rwe64;
    assign m_rwa[0] = rwa32;  assign m_rwa[1] = rwa32n;  assign m_rwa[2] = rwa64;
    assign m_rd[0]  = {32'b0, rd32}; assign m_rd[1] = {32'b0, rd32n}; assign m_rd[2] = rd64;
    assign m_hold[0] = hold32; assign m_hold[1] = hold32n; assign m_hold[2] = hold64;
    assign m_mis[0] = mis32;  assign m_mis[1] = mis32n;  assign m_mis[2] = mis64;
    assign m_rdy[0] = rdy32;  assign m_rdy[1] = rdy32n;  assign m_rdy[2] = rdy64;

    typedef struct { int d; logic [31:0] addr; logic we; logic [7:0] be; logic [63:0] wd; } beat_t;
    typedef struct { int d; logic [4:0] rd; logic [63:0] data; } wb_t;
    beat_t       bq[$];
    wb_t         wq[$];
    int          fq[$];
    logic [63:0] rq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int we_cyc = 0;
    bit mon_en = 1'b0;
    int gnt_delay = 0;
    int rv_delay = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic eb(input int d, input logic [31:0] a, input logic we, input logic [7:0] be, input logic [63:0] wd);
        beat_t b;
        b.d = d; b.addr = a; b.we = we; b.be = be; b.wd = wd;
        bq.push_back(b);
    endtask

    task automatic ew(input int d, input logic [4:0] rd, input logic [63:0] data);
        wb_t w;
        w.d = d; w.rd = rd; w.data = data;
        wq.push_back(w);
    endtask

    task automatic pop_rd(output logic [63:0] v);
        v = (rq.size() != 0) ? rq.pop_front() : 64'd0;
    endtask

    // Memory side: grant after gnt_delay request cycles, read data rv_delay cycles after grant
    int          wc [2];
    int          pc [2];
    logic [63:0] rv;
    initial begin
        b32.bus_gnt_i = 0;  b32.bus_rvalid_i = 0;  b32.bus_rdata_i = '0;
        b64.bus_gnt_i = 0;  b64.bus_rvalid_i = 0;  b64.bus_rdata_i = '0;
        b32n.bus_gnt_i = 1; b32n.bus_rvalid_i = 0; b32n.bus_rdata_i = '0;
        wc[0] = 0; wc[1] = 0; pc[0] = 0; pc[1] = 0;
        forever begin
            @(posedge clk); #1;
            b32.bus_gnt_i = 0; b32.bus_rvalid_i = 0;
            b64.bus_gnt_i = 0; b64.bus_rvalid_i = 0;
            if (pc[0] > 0) begin
                pc[0]--;
                if (pc[0] == 0) begin pop_rd(rv); b32.bus_rvalid_i = 1; b32.bus_rdata_i = rv[31:0]; end
            end else if (b32.bus_req_o) begin
                if (wc[0] < gnt_delay) wc[0]++;
                else begin b32.bus_gnt_i = 1; wc[0] = 0; if (!b32.bus_we_o) pc[0] = rv_delay; end
            end
            if (pc[1] > 0) begin
                pc[1]--;
                if (pc[1] == 0) begin pop_rd(rv); b64.bus_rvalid_i = 1; b64.bus_rdata_i = rv; end
            end else if (b64.bus_req_o) begin
                if (wc[1] < gnt_delay) wc[1]++;
                else begin b64.bus_gnt_i = 1; wc[1] = 0; if (!b64.bus_we_o) pc[1] = rv_delay; end
            end
        end
    end

    logic        p_wait [3];
    logic [31:0] p_addr [3];
    logic [7:0]  p_be [3];
    logic        p_we [3];
    logic [63:0] p_wd [3];
    beat_t       mb;
    wb_t         mw;
    int          mf;
    logic [63:0] lane;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                chk("ready_vs_hold", 64'(m_rdy[d]), 64'(!m_hold[d]));
                if (m_req[d] && p_wait[d]) begin
                    chk("req_stable_addr", 64'(m_addr[d]), 64'(p_addr[d]));
                    chk("req_stable_be", 64'(m_be[d]), 64'(p_be[d]));
                    chk("req_stable_we", 64'(m_we[d]), 64'(p_we[d]));
                    chk("req_stable_wdata", m_wd[d], p_wd[d]);
                end
                p_wait[d] <= m_req[d] && !m_gnt[d];
                p_addr[d] <= m_addr[d]; p_be[d] <= m_be[d]; p_we[d] <= m_we[d]; p_wd[d] <= m_wd[d];
                if (m_req[d] && m_gnt[d]) begin
                    chk("beat_expected", 64'(bq.size() != 0), 64'd1);
                    if (bq.size() != 0) begin
                        mb = bq.pop_front();
                        chk("beat_dut", 64'(d), 64'(mb.d));
                        chk("beat_addr", 64'(m_addr[d]), 64'(mb.addr));
                        chk("beat_we", 64'(m_we[d]), 64'(mb.we));
                        chk("beat_be", 64'(m_be[d]), 64'(mb.be));
                        if (mb.we) begin
                            for (int b = 0; b < 8; b++) lane[8*b +: 8] = {8{mb.be[b]}};
                            chk("beat_wdata", m_wd[d] & lane, mb.wd & lane);
                        end
                    end
                end
                if (m_rwe[d]) begin
                    we_cyc <= cyc;
                    chk("wb_expected", 64'(wq.size() != 0), 64'd1);
                    if (wq.size() != 0) begin
                        mw = wq.pop_front();
                        chk("wb_dut", 64'(d), 64'(mw.d));
                        chk("wb_waddr", 64'(m_rwa[d]), 64'(mw.rd));
                        chk("wb_data", m_rd[d], mw.data);
                    end
                end
                if (m_mis[d]) begin
                    chk("fault_expected", 64'(fq.size() != 0), 64'd1);
                    if (fq.size() != 0) begin
                        mf = fq.pop_front();
                        chk("fault_dut", 64'(d), 64'(mf));
                    end
                end
            end
        end
    end

    task automatic set_valid(input int d, input logic v);
        case (d)
            0:       v32 = v;
            1:       v32n = v;
            default: v64 = v;
        endcase
    endtask

    task automatic check_idle(input int d);
        chk("idle_bus_req", 64'(m_req[d]), 64'd0);
        chk("idle_bus_we", 64'(m_we[d]), 64'd0);
        chk("idle_bus_addr", 64'(m_addr[d]), 64'd0);
        chk("idle_bus_be", 64'(m_be[d]), 64'd0);
        chk("idle_bus_wdata", m_wd[d], 64'd0);
        chk("idle_rd_we", 64'(m_rwe[d]), 64'd0);
        chk("idle_rd_waddr", 64'(m_rwa[d]), 64'd0);
        chk("idle_rd_data", m_rd[d], 64'd0);
        chk("idle_hold", 64'(m_hold[d]), 64'd0);
        chk("idle_misalign", 64'(m_mis[d]), 64'd0);
        chk("idle_in_ready", 64'(m_rdy[d]), 64'd1);
    endtask

    // exp_hold: cycles with hold_flag_o high; exp_lat: edge after accept at which rd_we_o is sampled
    task automatic run_op(input int d, input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [63:0] sd, input logic [4:0] rd, input int exp_hold, input int exp_lat);
        int n;
        int acc;
        @(posedge clk); #1;
        t_store = st; t_f3 = f3; t_addr = a; t_sd = sd; t_rd = rd;
        set_valid(d, 1'b1);
        @(posedge clk); #1;
        set_valid(d, 1'b0);
        acc = cyc;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!m_hold[d]) break;
            n++;
        end
        chk("hold_cycles", 64'(n), 64'(exp_hold));
        if (exp_hold == 0) begin
            repeat (3) begin
                @(negedge clk);
                chk("fault_in_ready", 64'(m_rdy[d]), 64'd1);
                chk("fault_no_req", 64'(m_req[d]), 64'd0);
            end
        end
        if (exp_lat > 0) chk("wb_latency", 64'(we_cyc + 1 - acc), 64'(exp_lat));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; v32 = 0; v32n = 0; v64 = 0;
        t_store = 0; t_f3 = 0; t_addr = 0; t_sd = 0; t_rd = 0;
        for (int d = 0; d < 3; d++) p_wait[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d);
        mon_en = 1'b1;

        rq.push_back(64'h80112233); eb(0, 32'h1000, 0, 8'h08, 0); ew(0, 5'd5, 64'hFFFFFF80);
        run_op(0, 0, 3'b000, 32'h1003, 0, 5'd5, 3, 3);
        rq.push_back(64'h80112233); eb(0, 32'h1000, 0, 8'h08, 0); ew(0, 5'd6, 64'h00000080);
        run_op(0, 0, 3'b100, 32'h1003, 0, 5'd6, 3, 3);
        rq.push_back(64'h80112233); eb(0, 32'h1000, 0, 8'h0C, 0); ew(0, 5'd7, 64'hFFFF8011);
        run_op(0, 0, 3'b001, 32'h1002, 0, 5'd7, 3, 3);
        rq.push_back(64'h1234F00D); eb(0, 32'h1000, 0, 8'h03, 0); ew(0, 5'd8, 64'h0000F00D);
        run_op(0, 0, 3'b101, 32'h1000, 0, 5'd8, 3, 3);
        rq.push_back(64'h44332211); rq.push_back(64'h88776655);
        eb(0, 32'h1000, 0, 8'h0C, 0); eb(0, 32'h1004, 0, 8'h03, 0); ew(0, 5'd9, 64'h66554433);
        run_op(0, 0, 3'b010, 32'h1002, 0, 5'd9, 5, 5);
        eb(0, 32'h1000, 1, 8'h08, 64'hBB000000); eb(0, 32'h1004, 1, 8'h01, 64'h000000AA);
        run_op(0, 1, 3'b001, 32'h1003, 64'h0000AABB, 5'd0, 3, 0);
        gnt_delay = 3;
        eb(0, 32'h2000, 1, 8'h0F, 64'hDEADBEEF);
        run_op(0, 1, 3'b010, 32'h2000, 64'hDEADBEEF, 5'd0, 5, 0);
        gnt_delay = 0;
        eb(0, 32'h2000, 1, 8'h02, 64'h00005500);
        run_op(0, 1, 3'b000, 32'h2001, 64'h00000055, 5'd0, 2, 0);
        rq.push_back(64'h12345678); eb(0, 32'h3000, 0, 8'h0F, 0);
        run_op(0, 0, 3'b010, 32'h3000, 0, 5'd0, 3, 0);

        fq.push_back(0); run_op(0, 0, 3'b111, 32'h1000, 0, 5'd1, 0, 0);
        fq.push_back(0); run_op(0, 1, 3'b100, 32'h1000, 0, 5'd0, 0, 0);
        fq.push_back(0); run_op(0, 0, 3'b011, 32'h1000, 0, 5'd1, 0, 0);
        fq.push_back(1); run_op(1, 0, 3'b010, 32'h1001, 0, 5'd1, 0, 0);
        fq.push_back(1); run_op(1, 0, 3'b001, 32'h1003, 0, 5'd1, 0, 0);

        rv_delay = 2;
        rq.push_back(64'hCAFEF00D); eb(0, 32'h4000, 0, 8'h0F, 0);
        @(posedge clk); #1;
        t_store = 0; t_f3 = 3'b010; t_addr = 32'h4000; t_rd = 5'd4; v32 = 1'b1;
        @(posedge clk); #1 v32 = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_idle(0);
        repeat (4) @(posedge clk);
        rv_delay = 1;

        rq.push_back(64'h0123456789ABCDEF); eb(2, 32'h08, 0, 8'hFF, 0); ew(2, 5'd3, 64'h0123456789ABCDEF);
        run_op(2, 0, 3'b011, 32'h08, 0, 5'd3, 3, 3);
        rq.push_back(64'h80000000_11111111); eb(2, 32'h08, 0, 8'hF0, 0); ew(2, 5'd10, 64'hFFFFFFFF80000000);
        run_op(2, 0, 3'b010, 32'h0C, 0, 5'd10, 3, 3);
        rq.push_back(64'h80000000_11111111); eb(2, 32'h08, 0, 8'hF0, 0); ew(2, 5'd11, 64'h0000000080000000);
        run_op(2, 0, 3'b110, 32'h0C, 0, 5'd11, 3, 3);
        rq.push_back(64'h8877665544332211); rq.push_back(64'h00FFEEDDCCBBAA99);
        eb(2, 32'h08, 0, 8'hF0, 0); eb(2, 32'h10, 0, 8'h0F, 0); ew(2, 5'd12, 64'hCCBBAA9988776655);
        run_op(2, 0, 3'b011, 32'h0C, 0, 5'd12, 5, 5);
        eb(2, 32'h10, 1, 8'hFF, 64'h1122334455667788);
        run_op(2, 1, 3'b011, 32'h10, 64'h1122334455667788, 5'd0, 2, 0);

        repeat (4) @(posedge clk);
        chk("beats_left", 64'(bq.size()), 64'd0);
        chk("writebacks_left", 64'(wq.size()), 64'd0);
        chk("faults_left", 64'(fq.size()), 64'd0);
        chk("rdata_left", 64'(rq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
